// File: rtl/oam_dma_pkg.sv
// Shared constants and types for the OAM DMA engine.
//   DMA_REG_ADDR    : CPU register that starts a transfer and reads back its page
//   OAM_BASE        : CPU-visible base of sprite attribute memory
//   ECHO_FOLD_START : first source page that aliases work RAM through echo space
//   dma_state_t     : engine state encoding
//   fold_page()     : maps an echo-RAM source page onto the work-RAM page it mirrors
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
    localparam logic [15:0] OAM_BASE        = 16'hFE00;
    localparam logic [7:0]  ECHO_FOLD_START = 8'hE0;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_XFER
    } dma_state_t;

    // Pages E0-FF mirror C0-DF, so reads are redirected 0x20 pages down.
    function automatic logic [7:0] fold_page(input logic [7:0] page);
        return (page >= ECHO_FOLD_START) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU / source memory / OAM and the DMA engine.
//   cpu_*      : register write/read port (write strobe one cycle, readback combinational)
//   src_*      : source read port, data returns one cycle after src_re
//   oam_*      : OAM byte write port, oam_addr is the byte index 0..NUM_BYTES-1
//   dma_active : high for the whole transfer
// slave is the engine side, master is the system side.
interface oam_dma_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_sel;

    logic [15:0] src_addr;
    logic        src_re;
    logic [7:0]  src_rdata;

    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;

    logic        dma_active;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, src_rdata,
        output cpu_rdata, cpu_sel, src_addr, src_re,
               oam_addr, oam_wdata, oam_we, dma_active
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, src_rdata,
        input  cpu_rdata, cpu_sel, src_addr, src_re,
               oam_addr, oam_wdata, oam_we, dma_active
    );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a write of page XX to 0xFF46 copies XX00-XX9F into OAM,
// one byte per CYCLES_PER_BYTE clocks, after START_DELAY idle clocks.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : oam_dma_if.slave (CPU register port, source read port, OAM write port,
//           dma_active)
// Requires CYCLES_PER_BYTE >= 2, START_DELAY >= 1, NUM_BYTES <= 256.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int unsigned NUM_BYTES       = 160,
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned START_DELAY     = 4
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.slave  bus
);

    localparam int unsigned PH_W  = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLES_PER_BYTE - 1);
    localparam logic [PH_W-1:0]  PH_WRITE = PH_W'(1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_BYTES - 1);

    dma_state_t       state_q, state_d;
    logic [7:0]       reg_src_q, reg_src_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       idx_q, idx_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [DLY_W-1:0] delay_q, delay_d;

    logic trigger_c;
    logic sel_c;

    assign trigger_c = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

    // Register readback is combinational so the CPU sees it in the read cycle.
    assign sel_c         = bus.cpu_re && (bus.cpu_addr == DMA_REG_ADDR);
    assign bus.cpu_sel   = sel_c;
    assign bus.cpu_rdata = sel_c ? reg_src_q : 8'h00;

    assign bus.dma_active = (state_q != DMA_IDLE);

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            reg_src_q <= 8'h00;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            phase_q   <= '0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            reg_src_q <= reg_src_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            delay_q   <= delay_d;
        end
    end

    // Next state, counters and transfer strobes.
    always_comb begin
        state_d       = state_q;
        reg_src_d     = reg_src_q;
        page_d        = page_q;
        idx_d         = idx_q;
        phase_d       = phase_q;
        delay_d       = delay_q;
        bus.src_re    = 1'b0;
        bus.src_addr  = 16'h0000;
        bus.oam_we    = 1'b0;
        bus.oam_addr  = 8'h00;
        bus.oam_wdata = 8'h00;

        case (state_q)
            DMA_IDLE: ;
            DMA_START: begin
                if (delay_q == DLY_LAST) begin
                    state_d = DMA_XFER;
                    idx_d   = 8'h00;
                    phase_d = '0;
                end else begin
                    delay_d = delay_q + DLY_W'(1);
                end
            end
            DMA_XFER: begin
                if (phase_q == '0) begin
                    bus.src_re   = 1'b1;
                    bus.src_addr = {page_q, idx_q};
                end
                // Source data requested in phase 0 is on src_rdata now.
                if (phase_q == PH_WRITE) begin
                    bus.oam_we    = 1'b1;
                    bus.oam_addr  = idx_q;
                    bus.oam_wdata = bus.src_rdata;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DMA_IDLE;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = DMA_IDLE;
        endcase

        // A register write restarts from any state and cancels a same-cycle OAM write.
        if (trigger_c) begin
            state_d       = DMA_START;
            reg_src_d     = bus.cpu_wdata;
            page_d        = fold_page(bus.cpu_wdata);
            idx_d         = 8'h00;
            phase_d       = '0;
            delay_d       = '0;
            bus.oam_we    = 1'b0;
            bus.oam_wdata = 8'h00;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: 1-cycle-latency source memory, OAM shadow model,
// hand-computed expectations for timing, data, retrigger, reset and idle behaviour.
module tb_oam_dma;
    import oam_dma_pkg::*;

    localparam int unsigned NUM_BYTES = 160;
    localparam int unsigned CPB       = 4;
    localparam int unsigned SD        = 4;
    localparam int          ACT_CYC   = 644;   // 4 + 160*4
    localparam int          FIRST_SRC = 4;     // src_re in the 5th active cycle

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oam_dma_if bus();

    oam_dma #(
        .NUM_BYTES       (NUM_BYTES),
        .CYCLES_PER_BYTE (CPB),
        .START_DELAY     (SD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] src_mem [0:65535];
    logic [7:0] oam_mem [0:255] = '{default: 8'h00};
    logic [7:0] exp_page = 8'h00;
    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    int bad_src  = 0;
    int busy_cnt = 0;

    // Source memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.src_re) bus.src_rdata <= src_mem[bus.src_addr];
    end

    // OAM shadow and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.oam_we) begin
            oam_mem[bus.oam_addr] = bus.oam_wdata;
            we_cnt++;
        end
        if (bus.src_re && (bus.src_addr[15:8] != exp_page)) bad_src++;
        if (bus.src_re || bus.oam_we || bus.dma_active || bus.cpu_sel) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_we    = 1'b1;
        @(posedge clk); #1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic sel, output logic [7:0] data);
        bus.cpu_addr = a;
        bus.cpu_re   = 1'b1;
        #1;
        sel  = bus.cpu_sel;
        data = bus.cpu_rdata;
        bus.cpu_re   = 1'b0;
        bus.cpu_addr = 16'h0000;
    endtask

    task automatic run_until_idle(output int act, output int first_src);
        act = 0;
        first_src = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!bus.dma_active) break;
            if (bus.src_re && first_src < 0) first_src = act;
            act++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_we(input int target, output logic ok, output int drops);
        ok = 1'b0;
        drops = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (!bus.dma_active) drops++;
            if (we_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_oam(input string tag, input logic [7:0] key, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i <= hi; i++) begin
            if (oam_mem[i] !== (8'(i) ^ key)) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        if (NUM_BYTES > 256) $fatal(1, "FAIL num_bytes: NUM_BYTES above 256");
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       sel;
        logic [7:0] rd;
        logic       ok;
        int         act, first, drops, base, bsrc, bbusy;

        reset         = 1'b1;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        // Every page holds lo^hi; page C0 gets the i^5A pattern.
        for (int a = 0; a < 65536; a++) src_mem[a] = 8'(a) ^ 8'(a >> 8);
        for (int i = 0; i < 160; i++) src_mem[16'hC000 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        check("rst_active",   32'(bus.dma_active), 32'd0);
        check("rst_src_re",   32'(bus.src_re),     32'd0);
        check("rst_oam_we",   32'(bus.oam_we),     32'd0);
        check("rst_src_addr", 32'(bus.src_addr),   32'h0);
        check("rst_oam_addr", 32'(bus.oam_addr),   32'h0);
        check("rst_oam_wd",   32'(bus.oam_wdata),  32'h0);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("rst_sel",   32'(sel), 32'd1);
        check("rst_rdata", 32'(rd),  32'h00);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic copy from page C0.
        exp_page = 8'hC0;
        base = we_cnt; bsrc = bad_src;
        cpu_write(DMA_REG_ADDR, 8'hC0);
        run_until_idle(act, first);
        check("basic_active", 32'(act),            32'(ACT_CYC));
        check("basic_first",  32'(first),          32'(FIRST_SRC));
        check("basic_we_cnt", 32'(we_cnt - base),  32'd160);
        check("basic_srcpg",  32'(bad_src - bsrc), 32'd0);
        check_oam("basic_oam", 8'h5A, 0, 159);

        // Readback at the start, mid-transfer and after completion.
        exp_page = 8'h80;
        cpu_write(DMA_REG_ADDR, 8'h80);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("rb_t1_sel",   32'(sel), 32'd1);
        check("rb_t1_rdata", 32'(rd),  32'h80);
        repeat (298) @(posedge clk);
        #1;
        check("rb_mid_active", 32'(bus.dma_active), 32'd1);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("rb_mid_sel",   32'(sel), 32'd1);
        check("rb_mid_rdata", 32'(rd),  32'h80);
        run_until_idle(act, first);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("rb_end_rdata", 32'(rd), 32'h80);
        cpu_read(16'hFF47, sel, rd);
        check("rb_other_sel",   32'(sel), 32'd0);
        check("rb_other_rdata", 32'(rd),  32'h00);
        check_oam("rb_oam", 8'h80, 0, 159);

        // Echo page E1 reads from C1.
        exp_page = 8'hC1;
        bsrc = bad_src;
        cpu_write(DMA_REG_ADDR, 8'hE1);
        run_until_idle(act, first);
        check("echo_active", 32'(act),             32'(ACT_CYC));
        check("echo_srcpg",  32'(bad_src - bsrc),  32'd0);
        check_oam("echo_oam", 8'hC1, 0, 159);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("echo_rdata", 32'(rd), 32'hE1);

        // Retrigger to page D0 after 50 bytes.
        exp_page = 8'hC0;
        base = we_cnt; bsrc = bad_src;
        cpu_write(DMA_REG_ADDR, 8'hC0);
        wait_we(base + 50, ok, drops);
        check("retrig_reach50", 32'(ok), 32'd1);
        exp_page = 8'hD0;
        cpu_write(DMA_REG_ADDR, 8'hD0);
        check("retrig_active", 32'(bus.dma_active), 32'd1);
        run_until_idle(act, first);
        check("retrig_drops",  32'(drops),          32'd0);
        check("retrig_len",    32'(act),            32'(ACT_CYC));
        check("retrig_first",  32'(first),          32'(FIRST_SRC));
        check("retrig_we_cnt", 32'(we_cnt - base),  32'd210);
        check("retrig_srcpg",  32'(bad_src - bsrc), 32'd0);
        check_oam("retrig_oam", 8'hD0, 0, 159);

        // Write landing on the final OAM write cancels it.
        base = we_cnt;
        cpu_write(DMA_REG_ADDR, 8'hC0);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (bus.oam_we && bus.oam_addr == 8'd159) begin
                ok = 1'b1;
                break;
            end
        end
        check("last_reach159", 32'(ok), 32'd1);
        bus.cpu_addr  = DMA_REG_ADDR;
        bus.cpu_wdata = 8'hC2;
        bus.cpu_we    = 1'b1;
        #1;
        check("last_we_supp", 32'(bus.oam_we),     32'd0);
        check("last_active",  32'(bus.dma_active), 32'd1);
        @(posedge clk); #1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
        check("last_we_cnt", 32'(we_cnt - base), 32'd159);
        run_until_idle(act, first);
        check("last_len", 32'(act), 32'(ACT_CYC));
        check_oam("last_oam", 8'hC2, 0, 159);

        // Reset part way through page C3.
        base = we_cnt;
        cpu_write(DMA_REG_ADDR, 8'hC3);
        wait_we(base + 80, ok, drops);
        check("rstm_reach80", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        check("rstm_active",   32'(bus.dma_active), 32'd0);
        check("rstm_src_re",   32'(bus.src_re),     32'd0);
        check("rstm_oam_we",   32'(bus.oam_we),     32'd0);
        check("rstm_src_addr", 32'(bus.src_addr),   32'h0);
        check("rstm_oam_addr", 32'(bus.oam_addr),   32'h0);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("rstm_rdata", 32'(rd), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rstm_we_cnt", 32'(we_cnt - base), 32'd80);
        check_oam("rstm_oam_new", 8'hC3, 0, 79);
        check_oam("rstm_oam_old", 8'hC2, 80, 159);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_page = 8'h90;
        bsrc = bad_src;
        cpu_write(DMA_REG_ADDR, 8'h90);
        run_until_idle(act, first);
        check("rstm_rerun_len",   32'(act),            32'(ACT_CYC));
        check("rstm_rerun_srcpg", 32'(bad_src - bsrc), 32'd0);

        // Traffic to other addresses leaves the engine quiet.
        bbusy = busy_cnt;
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (a == DMA_REG_ADDR) a = 16'hFF45;
            bus.cpu_addr  = a;
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_re    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.cpu_we   = 1'b0;
        bus.cpu_re   = 1'b0;
        bus.cpu_addr = 16'h0000;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy_cnt - bbusy), 32'd0);
        cpu_read(DMA_REG_ADDR, sel, rd);
        check("idle_rdata", 32'(rd), 32'h90);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
